// File: rtl/xbar_demux_rr_arbiter.sv
// Round-robin arbiter that shares one downstream demux-bus slave port among
// N_MASTERS requesters. The request path is a combinational mux. An in-order
// ID FIFO records the owner of every granted transaction, so each response
// goes back to the master that issued it.
module xbar_demux_rr_arbiter #(
    parameter int N_MASTERS       = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_MASTERS-1:0]      m_req_i,
    input  logic [N_MASTERS*32-1:0]   m_add_i,
    input  logic [N_MASTERS-1:0]      m_we_i,
    input  logic [N_MASTERS*6-1:0]    m_atop_i,
    input  logic [N_MASTERS*32-1:0]   m_wdata_i,
    input  logic [N_MASTERS*4-1:0]    m_be_i,
    output logic [N_MASTERS-1:0]      m_gnt_o,
    output logic [N_MASTERS-1:0]      m_r_valid_o,
    output logic [N_MASTERS*32-1:0]   m_r_rdata_o,
    output logic [N_MASTERS-1:0]      m_busy_o,
    output logic                      s_req_o,
    output logic [31:0]               s_add_o,
    output logic                      s_we_o,
    output logic [5:0]                s_atop_o,
    output logic [31:0]               s_wdata_o,
    output logic [3:0]                s_be_o,
    input  logic                      s_gnt_i,
    input  logic                      s_r_valid_i,
    input  logic [31:0]               s_r_rdata_i,
    output logic                      err_o
);

    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] DEPTH = CW'(MAX_OUTSTANDING);

    // Master index arithmetic that wraps modulo N_MASTERS, which need not be a power of 2.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_MASTERS) begin
            sum = sum - N_MASTERS;
        end else begin
            sum = sum;
        end
        return IW'(sum);
    endfunction

    logic [IW-1:0] ptr_r;
    logic [IW-1:0] sel_s;
    logic [IW-1:0] mux_idx_s;
    logic [IW-1:0] head_s;
    logic          any_req_s;
    logic          full_s;
    logic          empty_s;
    logic          hs_s;
    logic          pop_s;
    logic [IW-1:0] fifo_r [MAX_OUTSTANDING];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] out_cnt_r [N_MASTERS];
    logic          err_r;

    // Round-robin scan: the first requester at or after ptr wins.
    always_comb begin
        sel_s     = '0;
        any_req_s = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!any_req_s && m_req_i[wrap_add(ptr_r, i)]) begin
                sel_s     = wrap_add(ptr_r, i);
                any_req_s = 1'b1;
            end else begin
                any_req_s = any_req_s;
            end
        end
    end

    // A push is blocked while the FIFO is full, even if a pop happens in the same cycle.
    always_comb begin
        full_s  = (count_r == DEPTH);
        empty_s = (count_r == '0);
        s_req_o = any_req_s & ~full_s;
        hs_s    = s_req_o & s_gnt_i;
        pop_s   = s_r_valid_i & ~empty_s;
        head_s  = fifo_r[rd_ptr_r];
    end

    // Forward the selected master's fields downstream; master 0's fields when idle.
    always_comb begin
        if (any_req_s) begin
            mux_idx_s = sel_s;
        end else begin
            mux_idx_s = '0;
        end
        s_add_o   = m_add_i[32*mux_idx_s +: 32];
        s_we_o    = m_we_i[mux_idx_s];
        s_atop_o  = m_atop_i[6*mux_idx_s +: 6];
        s_wdata_o = m_wdata_i[32*mux_idx_s +: 32];
        s_be_o    = m_be_i[4*mux_idx_s +: 4];
    end

    // Grant goes to the selected master; the response goes to the FIFO head.
    always_comb begin
        m_gnt_o     = '0;
        m_r_valid_o = '0;
        if (hs_s) begin
            m_gnt_o[sel_s] = 1'b1;
        end else begin
            m_gnt_o = '0;
        end
        if (pop_s) begin
            m_r_valid_o[head_s] = 1'b1;
        end else begin
            m_r_valid_o = '0;
        end
        m_r_rdata_o = {N_MASTERS{s_r_rdata_i}};
    end

    // The RR pointer moves past the winner only when a handshake completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_r <= '0;
        end else if (hs_s) begin
            ptr_r <= wrap_add(sel_s, 1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // ID FIFO storage. No reset is needed because count gates validity.
    always_ff @(posedge clk_i) begin
        if (hs_s) begin
            fifo_r[wr_ptr_r] <= sel_s;
        end else begin
            fifo_r[wr_ptr_r] <= fifo_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally at a power-of-2 depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (hs_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({hs_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Per-master outstanding counters that drive the busy flags.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < N_MASTERS; k++) begin
            if (rst_i) begin
                out_cnt_r[k] <= '0;
            end else begin
                case ({hs_s && (sel_s == IW'(k)), pop_s && (head_s == IW'(k))})
                    2'b10:   out_cnt_r[k] <= out_cnt_r[k] + CW'(1);
                    2'b01:   out_cnt_r[k] <= out_cnt_r[k] - CW'(1);
                    default: out_cnt_r[k] <= out_cnt_r[k];
                endcase
            end
        end
    end

    // A master is busy while it has any outstanding transaction.
    always_comb begin
        m_busy_o = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            m_busy_o[k] = (out_cnt_r[k] != '0);
        end
    end

    // A response that arrives with no owner is a sticky protocol error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if (s_r_valid_i && empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err_o = err_r;

endmodule

// File: tb/tb_xbar_demux_rr_arbiter.sv
// Self-checking bench for xbar_demux_rr_arbiter: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_xbar_demux_rr_arbiter;

    localparam int N = 4;
    localparam int M = 4;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [N-1:0]      m_req_i;
    logic [N*32-1:0]   m_add_i;
    logic [N-1:0]      m_we_i;
    logic [N*6-1:0]    m_atop_i;
    logic [N*32-1:0]   m_wdata_i;
    logic [N*4-1:0]    m_be_i;
    logic [N-1:0]      m_gnt_o;
    logic [N-1:0]      m_r_valid_o;
    logic [N*32-1:0]   m_r_rdata_o;
    logic [N-1:0]      m_busy_o;
    logic              s_req_o;
    logic [31:0]       s_add_o;
    logic              s_we_o;
    logic [5:0]        s_atop_o;
    logic [31:0]       s_wdata_o;
    logic [3:0]        s_be_o;
    logic              s_gnt_i;
    logic              s_r_valid_i;
    logic [31:0]       s_r_rdata_i;
    logic              err_o;

    always #5 clk = ~clk;

    xbar_demux_rr_arbiter #(.N_MASTERS(N), .MAX_OUTSTANDING(M)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_req_i(m_req_i), .m_add_i(m_add_i), .m_we_i(m_we_i), .m_atop_i(m_atop_i),
        .m_wdata_i(m_wdata_i), .m_be_i(m_be_i),
        .m_gnt_o(m_gnt_o), .m_r_valid_o(m_r_valid_o), .m_r_rdata_o(m_r_rdata_o),
        .m_busy_o(m_busy_o),
        .s_req_o(s_req_o), .s_add_o(s_add_o), .s_we_o(s_we_o), .s_atop_o(s_atop_o),
        .s_wdata_o(s_wdata_o), .s_be_o(s_be_o),
        .s_gnt_i(s_gnt_i), .s_r_valid_i(s_r_valid_i), .s_r_rdata_i(s_r_rdata_i),
        .err_o(err_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: owner queue, round-robin pointer, sticky error.
    int q[$];
    int mptr = 0;
    bit merr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_fields(input int k, input logic [31:0] add, input logic we,
                              input logic [5:0] atop, input logic [31:0] wdata, input logic [3:0] be);
        m_add_i[32*k +: 32]   = add;
        m_we_i[k]             = we;
        m_atop_i[6*k +: 6]    = atop;
        m_wdata_i[32*k +: 32] = wdata;
        m_be_i[4*k +: 4]      = be;
    endtask

    // Compare every output with the model for this cycle, then advance the model.
    task automatic model_cycle();
        int sel;
        int ms;
        int rr;
        bit any;
        bit full;
        bit push;
        logic [N-1:0] eg;
        logic [N-1:0] ev;
        logic [N-1:0] eb;
        full = (q.size() == M);
        any  = 1'b0;
        sel  = 0;
        for (int i = 0; i < N; i++) begin
            int c = (mptr + i) % N;
            if (!any && m_req_i[c]) begin
                any = 1'b1;
                sel = c;
            end
        end
        push = any && !full && s_gnt_i;
        eg = '0;
        if (push) eg[sel] = 1'b1;
        ev = '0;
        if (s_r_valid_i && q.size() > 0) ev[q[0]] = 1'b1;
        eb = '0;
        foreach (q[j]) eb[q[j]] = 1'b1;
        ms = any ? sel : 0;
        rr = $urandom_range(0, N-1);
        chk("s_req",   32'(s_req_o), 32'(any && !full));
        chk("m_gnt",   32'(m_gnt_o), 32'(eg));
        chk("m_rvld",  32'(m_r_valid_o), 32'(ev));
        chk("m_busy",  32'(m_busy_o), 32'(eb));
        chk("err",     32'(err_o), 32'(merr));
        chk("s_add",   s_add_o, m_add_i[32*ms +: 32]);
        chk("s_we",    32'(s_we_o), 32'(m_we_i[ms]));
        chk("s_atop",  32'(s_atop_o), 32'(m_atop_i[6*ms +: 6]));
        chk("s_wdata", s_wdata_o, m_wdata_i[32*ms +: 32]);
        chk("s_be",    32'(s_be_o), 32'(m_be_i[4*ms +: 4]));
        chk("rdata",   m_r_rdata_o[32*rr +: 32], s_r_rdata_i);
        if (s_r_valid_i && q.size() == 0) merr = 1'b1;
        if (s_r_valid_i && q.size() > 0) void'(q.pop_front());
        if (push) begin
            q.push_back(sel);
            mptr = (sel + 1) % N;
        end
    endtask

    // One clock: drive after the rising edge, then check at the falling edge.
    task automatic step(input logic [N-1:0] req, input logic gnt, input logic rv,
                        input logic [31:0] rd, input logic rst);
        @(posedge clk);
        #1;
        m_req_i     = req;
        s_gnt_i     = gnt;
        s_r_valid_i = rv;
        s_r_rdata_i = rd;
        rst_i       = rst;
        @(negedge clk);
        if (rst) begin
            q.delete();
            mptr = 0;
            merr = 1'b0;
        end else begin
            model_cycle();
        end
    endtask

    int order[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst_i = 1'b1; m_req_i = '0; s_gnt_i = 1'b0; s_r_valid_i = 1'b0; s_r_rdata_i = '0;
        m_add_i = '0; m_we_i = '0; m_atop_i = '0; m_wdata_i = '0; m_be_i = '0;
        for (int k = 0; k < N; k++)
            set_fields(k, 32'h0000_A000 + 32'(k) * 32'h10, k[0], 6'(k + 1), 32'h5500_0000 + 32'(k), 4'(k + 3));

        // Reset, then an idle cycle showing the reset state.
        step(4'b0000, 1'b0, 1'b0, 32'h0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 32'h0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_busy", 32'(m_busy_o), 32'h0);
        chk("rst_sreq", 32'(s_req_o), 32'h0);

        // Single master 2 read with a next-cycle response.
        set_fields(2, 32'h0000_1000, 1'b0, 6'h00, 32'h0, 4'hF);
        step(4'b0100, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t1_gnt", 32'(m_gnt_o), 32'h4);
        chk("t1_add", s_add_o, 32'h0000_1000);
        step(4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("t1_busy", 32'(m_busy_o), 32'h4);
        chk("t1_rvld", 32'(m_r_valid_o), 32'h4);
        chk("t1_rdata", m_r_rdata_o[95:64], 32'hDEAD_BEEF);
        step(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t1_idle", 32'(m_busy_o), 32'h0);

        // Round robin with all four masters requesting.
        step(4'b0000, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(4'b1111, 1'b1, (i > 0), 32'h100 + 32'(i), 1'b0);
            chk("rr_gnt", 32'(m_gnt_o), 32'd1 << order[i]);
            chk("rr_add", s_add_o, m_add_i[32*order[i] +: 32]);
        end
        step(4'b0000, 1'b0, 1'b1, 32'h200, 1'b0);

        // FIFO full: four grants and no response block further requests.
        step(4'b0000, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0);
            chk("full_sreq", 32'(s_req_o), 32'h0);
            chk("full_gnt", 32'(m_gnt_o), 32'h0);
        end
        step(4'b0001, 1'b1, 1'b1, 32'h300, 1'b0);
        chk("full_pop_sreq", 32'(s_req_o), 32'h0);
        step(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("full_reen_sreq", 32'(s_req_o), 32'h1);
        chk("full_reen_gnt", 32'(m_gnt_o), 32'h1);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b1, 32'h310 + 32'(i), 1'b0);

        // Simultaneous push and pop at count 2 (masters 1 then 3 outstanding).
        step(4'b0000, 1'b0, 1'b0, 32'h0, 1'b1);
        step(4'b0010, 1'b1, 1'b0, 32'h0, 1'b0);
        step(4'b1000, 1'b1, 1'b0, 32'h0, 1'b0);
        step(4'b0001, 1'b1, 1'b1, 32'h400, 1'b0);
        chk("pp_gnt", 32'(m_gnt_o), 32'h1);
        chk("pp_rvld", 32'(m_r_valid_o), 32'h2);
        step(4'b0000, 1'b0, 1'b1, 32'h401, 1'b0);
        chk("pp_busy", 32'(m_busy_o), 32'h9);
        chk("pp_head3", 32'(m_r_valid_o), 32'h8);
        step(4'b0000, 1'b0, 1'b1, 32'h402, 1'b0);
        chk("pp_head0", 32'(m_r_valid_o), 32'h1);

        // Stall with ptr at 2 and masters 1 and 3 requesting.
        step(4'b0010, 1'b1, 1'b0, 32'h0, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 32'h500, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b1010, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("stall_add", s_add_o, m_add_i[32*3 +: 32]);
            chk("stall_gnt", 32'(m_gnt_o), 32'h0);
        end
        step(4'b1010, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("stall_gnt3", 32'(m_gnt_o), 32'h8);
        step(4'b1010, 1'b0, 1'b1, 32'h501, 1'b0);
        chk("stall_ptr0", s_add_o, m_add_i[32*1 +: 32]);

        // Protocol error with an empty FIFO, then cleared by reset.
        step(4'b0000, 1'b0, 1'b1, 32'h600, 1'b0);
        chk("err_norvld", 32'(m_r_valid_o), 32'h0);
        step(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("err_set", 32'(err_o), 32'h1);
        step(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("err_sticky", 32'(err_o), 32'h1);
        step(4'b0000, 1'b0, 1'b0, 32'h0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("err_clr", 32'(err_o), 32'h0);

        // Reset mid-operation: a late response to a pre-reset grant raises err.
        step(4'b0100, 1'b1, 1'b0, 32'h0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 32'h0, 1'b1);
        step(4'b0000, 1'b0, 1'b1, 32'h700, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("late_err", 32'(err_o), 32'h1);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic rv;
            for (int k = 0; k < N; k++)
                set_fields(k, $urandom, 1'($urandom), 6'($urandom), $urandom, 4'($urandom));
            rv = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
            step(4'($urandom), 1'($urandom), rv, $urandom, ($urandom_range(0, 59) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
